// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard slice.
// Resource class indices, ALU no-op opcode and parameter limits.
package hazard_pkg;

    localparam int RES_IO    = 0;
    localparam int RES_DATA  = 1;
    localparam int RES_ADDR  = 2;
    localparam int RES_FLAGS = 3;

    localparam logic [3:0] ALU_NOP_OP = 4'b0111;

    localparam int DEPTH_MIN     = 1;
    localparam int DEPTH_MAX     = 8;
    localparam int FLUSH_EXT_MIN = 1;
    localparam int FLUSH_EXT_MAX = 15;
    localparam int FLUSH_CNT_W   = 4;

    // Flags are claimed by every ALU op except the no-op.
    function automatic logic flags_written(input logic [3:0] alu_op);
        return alu_op != ALU_NOP_OP;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_shift.sv
// Pending-write shift register for the hazard scoreboard.
// Holds on freeze, shifts a bubble in when nothing is claimed.
module sb_shift #(
    parameter int NRES  = 4,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            claim_en,
    input  logic [NRES-1:0] claim,
    output logic [NRES-1:0] busy
);

    logic [NRES-1:0] pend [DEPTH];

    // Advance claims one stage per unfrozen cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                pend[k] <= '0;
            end
        end else if (!hold) begin
            pend[0] <= claim_en ? claim : '0;
            for (int k = 1; k < DEPTH; k++) begin
                pend[k] <= pend[k-1];
            end
        end
    end

    // Any stage still holding a claim blocks readers.
    always_comb begin
        busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | pend[k];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: stall, flush and stall statistics.
// Pending writes tracked per resource class over DEPTH stages.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NRES      = 4,
    parameter int DEPTH     = 2,
    parameter int FLUSH_EXT = 1,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [NRES-1:0]    rd_mask,
    input  logic [NRES-1:0]    wr_mask,
    input  logic [NRES-1:0]    br_mask,
    input  logic               take_branch1,
    input  logic               pc_ret1,
    input  logic               interrupt,
    input  logic               extend_flush,
    input  logic               halt,
    input  logic               mem_miss,
    input  logic               stat_clr,
    output logic               hazard,
    output logic               branch_hazard,
    output logic               decoder_output_flush,
    output logic               decoder_input_flush,
    output logic [NRES-1:0]    busy_mask,
    output logic [STALL_W-1:0] stall_count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        FLUSH_CNT_W'(FLUSH_EXT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   data_hazard;
    logic                   freeze;
    logic                   trigger;
    logic                   claim_en;

    sb_shift #(
        .NRES  (NRES),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze),
        .claim_en (claim_en),
        .claim    (wr_mask),
        .busy     (busy_mask)
    );

    // Hazard and flush controls from scoreboard state and current inputs.
    always_comb begin
        freeze        = mem_miss | halt;
        data_hazard   = issue_valid & |(rd_mask & busy_mask);
        branch_hazard = issue_valid & |(br_mask & busy_mask);
        hazard        = data_hazard | branch_hazard | freeze;
        decoder_output_flush = take_branch1 | pc_ret1 | interrupt;
        trigger = (decoder_output_flush & extend_flush) | interrupt;
        decoder_input_flush = trigger | (flush_cnt != '0);
        claim_en = issue_valid & ~hazard & ~decoder_output_flush;
    end

    // Extended flush: reload on trigger, count down when not frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (trigger) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (flush_cnt != '0 && !freeze) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (hazard && stall_count != STALL_MAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the CPU's combinational hazard logic.
- Tracks in-flight writes to NRES resource classes (IO, data, call address, flags, ...) through a DEPTH-stage shift scoreboard, so hazard checks are no longer hard-wired to stages 1 and 2.
- Adds a multi-cycle decoder-input flush extension and a saturating stall counter.
- Sits beside the decoder; drives pipeline stall and flush controls.

Parameters:
- NRES, 4: number of tracked resource classes (width of the rd/wr masks).
- DEPTH, 2: number of post-decode stages whose pending writes block reads (1..8).
- FLUSH_EXT, 1: cycles decoder_input_flush stays high after an extended flush (1..15).
- STALL_W, 16: width of the stall counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode stage holds a valid instruction.
- rd_mask  in  NRES  resources read by the decoding instruction.
- wr_mask  in  NRES  resources written by the decoding instruction (flags bit set when alu_op != 4'b0111).
- br_mask  in  NRES  resources needed by a brx/jmp/call in decode (flags for brx, call-address for jmp/call).
- take_branch1  in  1  stage-1 taken brx or jmp.
- pc_ret1  in  1  stage-1 return.
- interrupt  in  1  interrupt entry.
- extend_flush  in  1  request an extended decoder-input flush.
- halt  in  1  halt request.
- mem_miss  in  1  d-cache read or write miss (freezes pipeline).
- stat_clr  in  1  synchronous clear of stall_count.
- hazard  out  1  stall decode and fetch.
- branch_hazard  out  1  branch operand pending.
- decoder_output_flush  out  1  kill the decode-stage output.
- decoder_input_flush  out  1  kill the decode-stage input.
- busy_mask  out  NRES  OR of all pending write masks.
- stall_count  out  STALL_W  cycles with hazard high, saturating.

Behaviour:
- State:
  - pend[1..DEPTH], each NRES bits.
  - flush_cnt, 4 bits.
  - stall_count.
  - Reset (async, rst_n=0) clears all three to 0. Reset mid-operation drops every pending claim immediately.
- busy_mask = OR of pend[1..DEPTH]. All outputs are combinational from state and inputs. At reset all outputs are 0 except those driven directly by halt, mem_miss or interrupt.
- branch_hazard = issue_valid & |(br_mask & busy_mask).
- data_hazard = issue_valid & |(rd_mask & busy_mask).
- hazard = data_hazard | branch_hazard | halt | mem_miss.
- decoder_output_flush = take_branch1 | pc_ret1 | interrupt.
- decoder_input_flush = interrupt | (decoder_output_flush & extend_flush) | (flush_cnt != 0).
- freeze = mem_miss | halt. When freeze is high, pend and flush_cnt hold.
- Scoreboard advance (when not frozen):
  - pend[1] <= (issue_valid & !hazard & !decoder_output_flush) ? wr_mask : 0.
  - pend[k] <= pend[k-1] for k = 2..DEPTH.
  - A claim therefore blocks readers for exactly DEPTH unfrozen cycles after issue.
  - Stalling inserts a bubble (zero claim). The entry's own write does not self-block.
- Flush extension:
  - A trigger is (decoder_output_flush & extend_flush) | interrupt.
  - On a trigger, flush_cnt <= FLUSH_EXT-1. Otherwise, if non-zero and not frozen, flush_cnt decrements.
  - decoder_input_flush is therefore high for FLUSH_EXT unfrozen cycles, starting in the trigger cycle.
  - A retrigger while counting reloads the counter (no accumulation).
  - Trigger while frozen: the load still happens; the decrement waits for unfreeze.
  - FLUSH_EXT=1 never leaves flush_cnt non-zero.
- stall_count:
  - Increments on each cycle with hazard=1 and saturates at all-ones.
  - stat_clr wins over increment (result 0 that cycle).
- Simultaneous flush and hazard: flush has priority for pend[1] (a bubble enters); hazard is still reported.
- DEPTH=1 degenerates to single-stage checking. No configuration writes X to any output.

Decomposition:
- Package hazard_pkg:
  - Resource index constants RES_IO=0, RES_DATA=1, RES_ADDR=2, RES_FLAGS=3.
  - ALU_NOP_OP=4'b0111.
  - Parameter range limits.
- Sub-module sb_shift (NRES x DEPTH shift register with hold and bubble insert, outputs OR-reduced busy mask).
- Flush counter and stall counter stay in the top.

Test Plan:
1. DEPTH=2: issue wr_mask=4'b0010 at cycle 0; issue rd_mask=4'b0010 at cycles 1..3 -> hazard=1 in cycles 1 and 2, 0 in cycle 3; stall_count=2.
2. Claim on bit 3 (flags), then brx with br_mask=4'b1000 next cycle -> branch_hazard=1 and hazard=1; br_mask=4'b0100 instead -> both 0.
3. mem_miss held 5 cycles with a pending claim -> busy_mask unchanged across miss, hazard=1 throughout; claim retires 2 cycles after miss drops.
4. FLUSH_EXT=3: take_branch1=1 with extend_flush=1 for one cycle -> decoder_input_flush high 3 cycles, decoder_output_flush 1 cycle; retrigger in cycle 2 -> high through cycle 4.
5. rst_n low mid-claim (busy_mask=4'b0011) -> busy_mask=0, flush_cnt=0, stall_count=0 asynchronously; reads after release show no hazard.
6. STALL_W=4 with halt held 20 cycles -> stall_count saturates at 15; stat_clr with hazard=1 -> 0.
